abro_multi_detector: RTL and testbench

- Parametrised ABRO ("await all, emit, restart") detector: N independent event inputs, arriving in any order and any grouping.
- Fires a one-cycle output once every input has been seen at least once since the last restart or fire.
- Supports one-shot or auto-rearm operation and keeps a saturating fire counter.
- Sits between event sources and downstream control logic in the state-machine test designs.

---
 rtl/abro_multi_detector.sv | 171 +++++++++++++++++
 tb/tb_abro_multi_detector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/abro_multi_detector.sv
// abro_multi_detector
//   "Await all, emit, restart" detector over N_EVENTS independent event strobes.
//   Events may arrive in any order and in any grouping. Once every event has been
//   seen since the last restart or fire, a one-cycle registered pulse is emitted.
//   A saturating counter records how many fires have happened.
//
//   Optional feature: define ABRO_MULTI_TIMEOUT_EN to abandon an incomplete round
//   TIMEOUT_CYCLES-1 cycles after its first event (timeout_pulse strobes once,
//   the collected set is dropped). Without the macro there is no timer and
//   timeout_pulse is tied low.
//
// Parameters
//   N_EVENTS        number of event inputs (1..32)
//   AUTO_REARM      1: resume collecting after a fire; 0: park until restart
//   CNT_W           fire counter width
//   TIMEOUT_CYCLES  timeout window in cycles (>=2, timeout build only)
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   restart        in   synchronous restart, active high, overrides everything but reset
//   ev             in   event strobes, bit i = event i this cycle
//   seen           out  registered set of events collected so far
//   state          out  current state encoding
//   o_pulse        out  one-cycle fire strobe, registered
//   fire_count     out  saturating fire count
//   timeout_pulse  out  one-cycle timeout strobe
//
// state     | meaning
// ----------+------------------------------------------------------------
// COLLECT   | accumulating events into seen
// FIRE      | set completed last cycle; o_pulse high for exactly this cycle
// DONE      | one-shot mode finished; waits for restart
// TIMEOUT   | round abandoned; timeout_pulse high for exactly this cycle

module abro_multi_detector #(
  parameter int N_EVENTS       = 4,
  parameter int AUTO_REARM     = 0,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                restart,
  input  logic [N_EVENTS-1:0] ev,
  output logic [N_EVENTS-1:0] seen,
  output logic [1:0]          state,
  output logic                o_pulse,
  output logic [CNT_W-1:0]    fire_count,
  output logic                timeout_pulse
);

  if (N_EVENTS < 1 || N_EVENTS > 32 || CNT_W < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("abro_multi_detector: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_COLLECT = 2'b00,
    S_FIRE    = 2'b01,
    S_DONE    = 2'b10,
    S_TIMEOUT = 2'b11
  } state_t;

  localparam logic [N_EVENTS-1:0] ALL_SEEN = '1;
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  state_t              state_q;
  state_t              state_d;
  logic [N_EVENTS-1:0] seen_d;
  logic [CNT_W-1:0]    count_d;
  logic [N_EVENTS-1:0] merged;

  assign merged = seen | ev;
  assign state  = state_q;

`ifdef ABRO_MULTI_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_d;
`endif

  always_comb begin
    state_d = state_q;
    seen_d  = seen;
    count_d = fire_count;
`ifdef ABRO_MULTI_TIMEOUT_EN
    timer_d = timer;
`endif
    if (restart) begin
      // Events arriving with restart belong to no round and are dropped.
      state_d = S_COLLECT;
      seen_d  = '0;
`ifdef ABRO_MULTI_TIMEOUT_EN
      timer_d = '0;
`endif
    end else begin
      case (state_q)
        S_COLLECT: begin
          seen_d = merged;
          // Completion wins over a timer expiring in the same cycle.
          if (merged == ALL_SEEN) begin
            state_d = S_FIRE;
            count_d = (fire_count == CNT_MAX) ? fire_count : fire_count + CNT_W'(1);
          end
`ifdef ABRO_MULTI_TIMEOUT_EN
          // The timer counts the cycle of the first event, so it reaches
          // TIMER_LAST TIMEOUT_CYCLES-1 cycles after that event.
          else if (timer == TIMER_LAST) begin
            state_d = S_TIMEOUT;
          end else if (merged != '0) begin
            timer_d = timer + TIMER_W'(1);
          end
`endif
        end
        S_FIRE: begin
`ifdef ABRO_MULTI_TIMEOUT_EN
          timer_d = '0;
`endif
          if (AUTO_REARM != 0) begin
            // Events during the fire cycle open the next round.
            state_d = S_COLLECT;
            seen_d  = ev;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_COLLECT;
          seen_d  = '0;
`ifdef ABRO_MULTI_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_COLLECT;
      seen       <= '0;
      fire_count <= '0;
      o_pulse    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seen       <= seen_d;
      fire_count <= count_d;
      o_pulse    <= (state_d == S_FIRE);
    end
  end

`ifdef ABRO_MULTI_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timer         <= timer_d;
      timeout_pulse <= (state_d == S_TIMEOUT);
    end
  end
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_abro_multi_detector.sv
module tb_abro_multi_detector;

  localparam int TC = 4;

  // Model phases, numbered as the state output reports them.
  localparam int COL = 0;
  localparam int FIR = 1;
  localparam int DON = 2;
  localparam int TMO = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] ev = 4'h0;

  logic [3:0] seen0, seen1;
  logic [1:0] state0, state1;
  logic       pulse0, pulse1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic       tp0, tp1;

  always #5 clk = ~clk;

  abro_multi_detector #(.N_EVENTS(4), .AUTO_REARM(0), .CNT_W(8), .TIMEOUT_CYCLES(TC)) dut0 (
    .clk(clk), .reset(reset), .restart(restart), .ev(ev),
    .seen(seen0), .state(state0), .o_pulse(pulse0), .fire_count(cnt0), .timeout_pulse(tp0)
  );

  abro_multi_detector #(.N_EVENTS(4), .AUTO_REARM(1), .CNT_W(2), .TIMEOUT_CYCLES(TC)) dut1 (
    .clk(clk), .reset(reset), .restart(restart), .ev(ev),
    .seen(seen1), .state(state1), .o_pulse(pulse1), .fire_count(cnt1), .timeout_pulse(tp1)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] seen;
    logic       pulse;
    logic [7:0] cnt;
    logic       tp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;

  // Reference model: per instance, the phase, the collected set, fire tally,
  // and the cycle number at which the current round saw its first event.
  int m_mode[2];
  int m_seen[2];
  int m_fc[2];
  int m_first[2];
  int m_max[2];
  int m_auto[2];
  int now = 0;
  bit prev_r = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit rs, input logic [3:0] e);
    int u;
    if (!r) begin
      m_mode[k] = COL; m_seen[k] = 0; m_fc[k] = 0; m_first[k] = -1;
      return;
    end
    if (rs) begin
      m_mode[k] = COL; m_seen[k] = 0; m_first[k] = -1;
      return;
    end
    case (m_mode[k])
      COL: begin
        u = m_seen[k] | int'(e);
        if (m_first[k] < 0 && u != 0) m_first[k] = now;
        m_seen[k] = u;
        if (u == 15) begin
          m_mode[k] = FIR;
          if (m_fc[k] < m_max[k]) m_fc[k]++;
        end
`ifdef ABRO_MULTI_TIMEOUT_EN
        else if (m_first[k] >= 0 && now - m_first[k] == TC - 1) begin
          m_mode[k] = TMO;
        end
`endif
      end
      FIR: begin
        m_first[k] = -1;
        if (m_auto[k] != 0) begin
          m_mode[k] = COL;
          m_seen[k] = int'(e);
        end else begin
          m_mode[k] = DON;
        end
      end
      TMO: begin
        m_mode[k] = COL; m_seen[k] = 0; m_first[k] = -1;
      end
      default: ;
    endcase
  endtask

  function automatic exp_t snap(input int k);
    exp_t x;
    x.st    = 2'(m_mode[k]);
    x.seen  = 4'(m_seen[k]);
    x.pulse = (m_mode[k] == FIR);
    x.cnt   = 8'(m_fc[k]);
    x.tp    = (m_mode[k] == TMO);
    return x;
  endfunction

  // Drive one cycle of stimulus and queue what each DUT must show after the edge.
  task automatic step(input bit r, input bit rs, input logic [3:0] e);
    @(negedge clk);
    reset = r;
    restart = rs;
    ev = e;
    for (int k = 0; k < 2; k++) model_step(k, r, rs, e);
    q0.push_back(snap(0));
    q1.push_back(snap(1));
    now++;
    if (!r && prev_r) begin
      #1;
      chk("async_reset.dut0.o_pulse", {31'd0, pulse0}, 32'd0);
      chk("async_reset.dut1.o_pulse", {31'd0, pulse1}, 32'd0);
      chk("async_reset.dut0.state", {30'd0, state0}, 32'd0);
      chk("async_reset.dut1.seen", {28'd0, seen1}, 32'd0);
      chk("async_reset.dut0.fire_count", {24'd0, cnt0}, 32'd0);
      chk("async_reset.dut1.fire_count", {30'd0, cnt1}, 32'd0);
    end
    prev_r = r;
  endtask

  // Monitor: compares every registered output one step after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        x = q0.pop_front();
        chk("dut0.state", {30'd0, state0}, {30'd0, x.st});
        chk("dut0.seen", {28'd0, seen0}, {28'd0, x.seen});
        chk("dut0.o_pulse", {31'd0, pulse0}, {31'd0, x.pulse});
        chk("dut0.fire_count", {24'd0, cnt0}, {24'd0, x.cnt});
        chk("dut0.timeout_pulse", {31'd0, tp0}, {31'd0, x.tp});
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        chk("dut1.state", {30'd0, state1}, {30'd0, x.st});
        chk("dut1.seen", {28'd0, seen1}, {28'd0, x.seen});
        chk("dut1.o_pulse", {31'd0, pulse1}, {31'd0, x.pulse});
        chk("dut1.fire_count", {30'd0, cnt1}, {30'd0, x.cnt[1:0]});
        chk("dut1.timeout_pulse", {31'd0, tp1}, {31'd0, x.tp});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] e;
    bit r, rs;
    m_max[0] = 255; m_auto[0] = 0;
    m_max[1] = 3;   m_auto[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = COL; m_seen[k] = 0; m_fc[k] = 0; m_first[k] = -1;
    end

    step(0, 0, 4'h0);
    step(0, 0, 4'h0);

    // Events one at a time in scrambled order.
    step(1, 0, 4'h1);
    step(1, 0, 4'h4);
    step(1, 0, 4'h2);
    step(1, 0, 4'h8);
    repeat (3) step(1, 0, 4'h0);

    // Whole set in one cycle, then again in the next two cycles.
    step(1, 1, 4'h0);
    repeat (3) step(1, 0, 4'hF);
    repeat (2) step(1, 0, 4'h0);

    // Restart discards the collected set and its own-cycle events.
    step(1, 1, 4'h0);
    step(1, 0, 4'h3);
    step(1, 1, 4'hC);
    step(1, 0, 4'hC);
    step(1, 0, 4'h0);

    // Counter saturation with the full set held.
    step(1, 1, 4'h0);
    repeat (10) step(1, 0, 4'hF);
    step(1, 0, 4'h0);

    // Reset asserted while in FIRE.
    step(1, 1, 4'h0);
    step(1, 0, 4'hF);
    step(0, 0, 4'h0);
    step(0, 0, 4'h0);
    step(1, 0, 4'h0);

    // Lone event left to age, then completion landing on the expiry cycle.
    step(1, 0, 4'h1);
    repeat (5) step(1, 0, 4'h0);
    step(1, 1, 4'h0);
    step(1, 0, 4'h1);
    step(1, 0, 4'h0);
    step(1, 0, 4'h0);
    step(1, 0, 4'hE);
    repeat (2) step(1, 0, 4'h0);

    // Random traffic with occasional restarts and resets.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) != 0);
      rs = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) e = 4'hF;
      else e = 4'($urandom & $urandom);
      step(r, rs, e);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
